// File: rtl/tnoc_output_credit_manager_if.sv
// rtl/tnoc_output_credit_manager_if.sv - flit/credit event and availability bundle for one output port
interface tnoc_output_credit_manager_if #(
    parameter int CHANNELS = 2,
    parameter int CW       = 3
);
    logic [CHANNELS-1:0]    i_flit_sent;
    logic [CHANNELS-1:0]    i_credit_return;
    logic                   i_clear;
    logic [CHANNELS-1:0]    o_vc_available;
    logic [CHANNELS*CW-1:0] o_credit_count;
    logic                   o_error;
    logic [CHANNELS-1:0]    o_error_vc;

    modport master (
        output i_flit_sent, i_credit_return, i_clear,
        input  o_vc_available, o_credit_count, o_error, o_error_vc
    );

    modport slave (
        input  i_flit_sent, i_credit_return, i_clear,
        output o_vc_available, o_credit_count, o_error, o_error_vc
    );
endinterface

// File: rtl/tnoc_output_credit_manager.sv
// rtl/tnoc_output_credit_manager.sv - per-VC downstream credit counters with violation freeze and clear
module tnoc_output_credit_manager #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    tnoc_output_credit_manager_if.slave     port
);
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t                         state_q, state_d;
    logic [CHANNELS-1:0][CW-1:0]    count_q, count_d;
    logic [CHANNELS-1:0]            err_vc_q, err_vc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            count_q  <= '0;
            err_vc_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            err_vc_q <= err_vc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        err_vc_d = err_vc_q;
        case (state_q)
            ST_INIT: begin
                for (int i = 0; i < CHANNELS; i++) count_d[i] = FULL;
                err_vc_d = '0;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (port.i_clear) begin
                    // Clear outranks any violation seen on the same edge
                    err_vc_d = '0;
                    state_d  = ST_INIT;
                end else begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (port.i_flit_sent[i] && !port.i_credit_return[i]) begin
                            if (count_q[i] == '0) err_vc_d[i] = 1'b1;
                            else                  count_d[i]  = count_q[i] - CW'(1);
                        end else if (port.i_credit_return[i] && !port.i_flit_sent[i]) begin
                            if (count_q[i] == FULL) err_vc_d[i] = 1'b1;
                            else                    count_d[i]  = count_q[i] + CW'(1);
                        end
                    end
                    if (err_vc_d != '0) state_d = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (port.i_clear) begin
                    err_vc_d = '0;
                    state_d  = ST_INIT;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Availability comes only from registered state; no same-cycle credit bypass
    always_comb begin
        port.o_vc_available = '0;
        for (int i = 0; i < CHANNELS; i++)
            port.o_vc_available[i] = (state_q == ST_RUN) && (count_q[i] != '0);
    end

    assign port.o_credit_count = count_q;
    assign port.o_error        = (state_q == ST_ERROR);
    assign port.o_error_vc     = err_vc_q;
endmodule
